mux_nx1_stream: RTL and testbench
=================================

Name: mux_nx1_stream

Overview:
- Parametrised N-channel, WIDTH-bit registered stream multiplexer; successor to the 2:1 combinational mux.
- Two selection modes: static select (`s` picks the channel) and round-robin arbitration among valid channels.
- Valid/ready handshake on every input and on the output; single output register; 1-cycle latency; full throughput.
- Sits between multiple producer blocks and one shared consumer in the behavioral project.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels; must be ≥ 2.
- SELW, 2, select/channel-index width; must satisfy 2^SELW ≥ N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = static select, 1 = round-robin.
- s  input  SELW  channel select, used in static mode only.
- in_valid  input  N  per-channel valid.
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready (combinational).
- y  output  WIDTH  registered output data.
- y_valid  output  1  output holds a word.
- y_ready  input  1  consumer accepts the word.
- y_ch  output  SELW  index of the channel the current `y` came from.

Behaviour:
- Reset (asynchronous, while rst=1):
  - y=0, y_valid=0, y_ch=0, round-robin pointer ptr=0.
  - in_ready is all-zero while rst=1.
- load_en = !y_valid || y_ready. The output register accepts a new word only when load_en=1.
- Grant selection (combinational):
  - Static mode: grant = s if s < N and in_valid[s]=1. Otherwise there is no grant.
  - Round-robin mode: grant = the first k with in_valid[k]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N). If no input is valid, there is no grant.
- in_ready[grant] = load_en. All other in_ready bits are 0.
  - Static mode with s ≥ N: all in_ready are 0 and nothing transfers.
  - In_ready never depends on in_valid of the same channel except through grant selection.
- Transfer (clock edge where grant exists and load_en=1):
  - y ← in_data[grant]
  - y_ch ← grant
  - y_valid ← 1
- No transfer and y_ready=1: y_valid ← 0. y and y_ch hold their last values.
- Output stall (y_valid=1, y_ready=0): y, y_ch and y_valid hold stable. No input transfers.
- Simultaneous pop and push (y_valid=1, y_ready=1, grant exists): the old word leaves and the new word loads in the same edge. Throughput is 1 word/cycle.
- Latency: an input accepted at edge t appears on y with y_valid=1 immediately after edge t.
- Round-robin pointer:
  - On a transfer in round-robin mode, ptr ← (grant+1) mod N, wrapping from N-1 to 0.
  - Without a transfer, or in static mode, ptr holds.
- Mode or `s` changes take effect in the same cycle (combinational grant). The word already in the output register is unaffected.
- Reset asserted mid-transfer clears the output immediately. A word held but not yet accepted is dropped. After release, arbitration restarts at ptr=0.
- No width growth. Data passes bit-exact.

Test Plan:
- Reset then static mode, N=4, s=2, in_valid=4'b0100, in_data ch2=8'hA5, y_ready=1 → in_ready=4'b0100. Next cycle: y=8'hA5, y_valid=1, y_ch=2.
- Static mode, s=1, in_valid=4'b1101 (ch1 idle) → in_ready=0 and y_valid falls to 0. Also s=3'b111 with N=4 (SELW=3 build) → no transfer.
- Round-robin, all four valid continuously, y_ready=1, data = channel index → y_ch sequence 0,1,2,3,0,1 on consecutive cycles, one word per cycle.
- Round-robin, in_valid=4'b1010, ptr=0 → grants ch1 then ch3 then ch1, checking wrap from ch3 past 0 to ch1.
- Backpressure: y_valid=1, y=8'h3C, y_ready held 0 for 3 cycles → y stays 8'h3C, in_ready=0 throughout. y_ready=1 → next word loads in the same edge.
- Assert rst mid-stream with y_valid=1 → y=0, y_valid=0, y_ch=0 immediately without a clock. After release in round-robin with all valid, the first grant is ch0.

Source files
------------

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: N-channel registered stream mux with static-select or round-robin
// arbitration, valid/ready on every port, one output register, full throughput.
module mux_nx1_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    s,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   y,
    output logic               y_valid,
    input  logic               y_ready,
    output logic [SELW-1:0]    y_ch
);
    logic [WIDTH-1:0] y_q, y_d, sel_data;
    logic [SELW-1:0]  y_ch_q, y_ch_d, ptr_q, ptr_d, gnt, hi_gnt, lo_gnt;
    logic             y_valid_q, y_valid_d, gnt_ok, hi_ok, lo_ok, load_en, xfer;

    assign load_en = !y_valid_q || y_ready;

    // Round-robin: lowest valid channel at or above ptr, else lowest valid overall.
    always_comb begin
        hi_gnt = '0;
        hi_ok  = 1'b0;
        lo_gnt = '0;
        lo_ok  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                lo_gnt = SELW'(k);
                lo_ok  = 1'b1;
                if (SELW'(k) >= ptr_q) begin
                    hi_gnt = SELW'(k);
                    hi_ok  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt    = mode ? (hi_ok ? hi_gnt : lo_gnt) : s;
        gnt_ok = mode ? (hi_ok || lo_ok) : 1'b0;
        for (int k = 0; k < N; k++)
            if (!mode && s == SELW'(k)) gnt_ok = in_valid[k];
    end

    always_comb begin
        sel_data = '0;
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt == SELW'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
            in_ready[k] = !rst && gnt_ok && load_en && gnt == SELW'(k);
        end
    end

    assign xfer = gnt_ok && load_en;

    always_comb begin
        y_d       = xfer ? sel_data : y_q;
        y_ch_d    = xfer ? gnt : y_ch_q;
        y_valid_d = xfer ? 1'b1 : (y_ready ? 1'b0 : y_valid_q);
        ptr_d     = (xfer && mode) ? ((int'(gnt) == N - 1) ? '0 : gnt + SELW'(1)) : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            y_q       <= y_d;
            y_ch_q    <= y_ch_d;
            y_valid_q <= y_valid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;
endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb_mux_nx1_stream: directed and randomized checks of mux_nx1_stream against
// a cycle-level behavioural model of the stream mux.
module tb_mux_nx1_stream;
    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b1, mode = 1'b0, y_ready = 1'b0;
    logic [1:0]   s = '0;
    logic [2:0]   s3 = 3'd7;
    logic [N-1:0] in_valid = '0;
    logic [W-1:0] d [N];
    logic [N*W-1:0] in_data;
    logic [N-1:0] in_ready, in_ready3;
    logic [W-1:0] y, y3;
    logic         y_valid, y_valid3;
    logic [1:0]   y_ch;
    logic [2:0]   y_ch3;

    logic [W-1:0] m_y;
    logic         m_yv;
    int           m_ych, m_ptr;
    int           n_chk = 0, n_pass = 0;

    assign in_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    mux_nx1_stream #(.WIDTH(W), .N(N), .SELW(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .s(s), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_ch(y_ch)
    );

    mux_nx1_stream #(.WIDTH(W), .N(N), .SELW(3)) dut3 (
        .clk(clk), .rst(rst), .mode(1'b0), .s(s3), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready3), .y(y3), .y_valid(y_valid3), .y_ready(y_ready), .y_ch(y_ch3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int model_grant();
        if (!mode) return in_valid[s] ? int'(s) : -1;
        for (int j = 0; j < N; j++)
            if (in_valid[(m_ptr + j) % N]) return (m_ptr + j) % N;
        return -1;
    endfunction

    task automatic cycle();
        int   g;
        logic le;
        #1;
        g  = model_grant();
        le = !m_yv || y_ready;
        check("in_ready", in_ready, (g >= 0 && le) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        #1;
        if (g >= 0 && le) begin
            m_y   = d[g];
            m_ych = g;
            m_yv  = 1'b1;
            if (mode) m_ptr = (g + 1) % N;
        end else if (y_ready) begin
            m_yv = 1'b0;
        end
        check("y_valid", y_valid, m_yv);
        check("y", y, m_y);
        check("y_ch", y_ch, m_ych);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_y", y, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_y_ch", y_ch, 0);
        check("rst_in_ready", in_ready, 0);
        m_y   = '0;
        m_yv  = 1'b0;
        m_ych = 0;
        m_ptr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp_rr[3] = '{1, 3, 1};
        foreach (d[k]) d[k] = '0;
        mode     = 1'b1;
        in_valid = 4'hF;
        y_ready  = 1'b1;
        do_reset();

        mode = 1'b0; s = 2'd2; in_valid = 4'b0100; d[2] = 8'hA5;
        cycle();
        check("static_y", y, 8'hA5);
        check("static_ch", y_ch, 2);

        s = 2'd1; in_valid = 4'b1101;
        cycle();
        check("idle_sel_yv", y_valid, 0);

        in_valid = 4'hF;
        repeat (3) begin
            cycle();
            check("s_oob_ready", in_ready3, 0);
            check("s_oob_yv", y_valid3, 0);
        end

        mode = 1'b1; in_valid = 4'hF;
        foreach (d[k]) d[k] = W'(k);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_seq", y_ch, i % 4);
        end

        check("pre_rst_yv", y_valid, 1);
        do_reset();
        cycle();
        check("rst_first_gnt", y_ch, 0);

        do_reset();
        in_valid = 4'b1010; d[1] = 8'h11; d[3] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rr_wrap", y_ch, exp_rr[i]);
        end

        mode = 1'b0; s = 2'd0; in_valid = 4'b0001; d[0] = 8'h3C; y_ready = 1'b1;
        cycle();
        check("bp_first", y, 8'h3C);
        y_ready = 1'b0; d[0] = 8'h55;
        repeat (3) begin
            cycle();
            check("bp_hold", y, 8'h3C);
        end
        y_ready = 1'b1;
        cycle();
        check("bp_load", y, 8'h55);

        repeat (300) begin
            mode     = 1'($urandom);
            s        = 2'($urandom);
            in_valid = 4'($urandom);
            foreach (d[k]) d[k] = 8'($urandom);
            y_ready  = ($urandom % 4) != 0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
